cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle fetch/decode/execute sequencer for the 16-bit-instruction, 8-bit-data processor. It owns the program counter and instruction register, and steps each instruction through fixed phases. It also gates the write strobes from the combinational control unit (register file, data memory, flags) so each one fires in exactly one cycle per instruction. It sits between instruction memory and the control unit/ALU/register file/SyncRAM, and exposes run, single-step and halt control to the board-level top.

## Interface
Parameters:
- HALT_OPCODE, 5'b11111, opcode that halts the core after its writeback
- PC_RESET, 8'h00, PC value loaded on reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset: one clock, and reset is synchronous and active-low
- run  in  1  level; continuous execution while high
- step  in  1  one-cycle pulse; execute exactly one instruction from IDLE
- finish  in  1  halt request; honoured at the next writeback
- instr_in  in  16  instruction-memory read data at address pc
- reg_write_in  in  1  control-unit register-write decode
- dm_write_in  in  1  control-unit data-memory-write decode
- flags_write_in  in  1  control-unit flag-write decode
- mem_access_in  in  1  control-unit memory-access decode
- will_jump  in  1  jump-taken from the jump-condition logic
- pc  out  8  instruction address
- ir  out  16  latched instruction; opcode = ir[15:11], ra = ir[10:9], rb = ir[8:7], imm = ir[8:1]
- reg_we  out  1  register-file write strobe
- dm_we  out  1  data-memory write strobe
- flags_we  out  1  ALU flag-register write strobe
- state  out  3  current FSM state
- busy  out  1  high in FETCH..WB
- halted  out  1  high in HALT
- instr_count  out  16  retired instructions, saturating

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is illegal and goes to HALT on the next edge.
- IDLE to FETCH when run=1 or step=1. Latch step_mode = step & ~run; run wins when both are high.
- FETCH: ir <= instr_in at the end of the cycle, then go to DECODE.
- DECODE: one settle cycle for the control unit, which reads ir. Go to EXEC.
- EXEC: flags_we = flags_write_in. Go to MEM if mem_access_in, else to WB.
- MEM: dm_we = dm_write_in. Go to WB.
- WB actions:
  - reg_we = reg_write_in & ~dm_write_in.
  - pc <= will_jump ? ir[8:1] : pc + 1. The increment wraps 8'hFF to 8'h00.
  - instr_count increments and saturates at 16'hFFFF.
- WB next state, by priority:
  1. HALT if finish_pending, finish, or ir[15:11]==HALT_OPCODE.
  2. IDLE if step_mode.
  3. FETCH if run.
  4. IDLE otherwise.
- finish_pending: set by finish in any state other than HALT, cleared on entering HALT. An in-flight instruction always completes.
- HALT is absorbing. pc, ir and instr_count hold. Only rst_n leaves it.
- step pulses received while busy or halted are ignored. They are not queued.
- Dropping run mid-instruction finishes the current instruction, then goes to IDLE.
- All strobes (reg_we, dm_we, flags_we) are combinational from the state and are zero outside their single state.

## Timing
- Reset values on the edge where rst_n=0:
  - state=IDLE, pc=PC_RESET, ir=16'h0000, instr_count=0.
  - finish_pending=0, step_mode=0.
  - busy=0, halted=0, all strobes 0.
- Reset overrides any state, including mid-instruction and HALT. No partial write completes after the reset edge.
- Latency:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Memory instruction: 5 cycles.
  - First FETCH is the cycle after run/step is sampled high in IDLE.
- Back-to-back under run: the FETCH of instruction n+1 immediately follows the WB of n. There are no bubbles.
- Register write, PC update and count update all commit on the same edge that ends WB.
- instr_in must be valid in FETCH, i.e. one cycle after pc changes. Instruction memory is asynchronous.

## Test plan
- Reset then run=1 with instructions ADD (non-mem) at 0x00 and 0x01 → state sequence 0,1,2,3,5,1,2,3,5; pc reaches 0x02 after cycle 9; reg_we high exactly in cycles 5 and 9; instr_count=2.
- Store instruction (mem_access_in=1, dm_write_in=1, reg_write_in=1) → dm_we high one cycle in MEM; reg_we stays 0 in WB; 5-cycle latency.
- Taken jump with ir[8:1]=0x40 at pc=0x10 → pc=0x40 after WB. Non-jump at pc=0xFF → pc wraps to 0x00.
- run=0 with a single step pulse → exactly one instruction retires and the sequencer returns to IDLE. A second step pulse during DECODE is ignored; instr_count=1.
- finish pulsed during EXEC → the instruction completes its WB, then halted=1 and state=6 persist with run=1. Executing HALT_OPCODE also halts. rst_n=0 then restores state=0, pc=0x00 and instr_count=0.
- rst_n asserted during MEM of a store → dm_we=0 from the reset edge, and state/pc/ir are at their reset values on the following cycle.

Source files
------------

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle fetch/decode/execute sequencer for the 16-bit-instruction,
// 8-bit-data core. Owns the program counter and the instruction register,
// walks each instruction through FETCH/DECODE/EXEC/(MEM)/WB, and gates the
// control-unit write decodes so each strobe fires in exactly one cycle per
// instruction.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   run            level, continuous execution while high
//   step           one-cycle pulse, executes one instruction from IDLE
//   finish         halt request, honoured at the next writeback
//   instr_in       instruction-memory read data at address pc (async memory)
//   reg_write_in   control-unit register-write decode
//   dm_write_in    control-unit data-memory-write decode
//   flags_write_in control-unit flag-write decode
//   mem_access_in  control-unit memory-access decode
//   will_jump      jump-taken from the jump-condition logic
//   pc             instruction address
//   ir             latched instruction
//   reg_we         register-file write strobe (WB only)
//   dm_we          data-memory write strobe (MEM only)
//   flags_we       flag-register write strobe (EXEC only)
//   state          current FSM state
//   busy           high in FETCH..WB
//   halted         high in HALT
//   instr_count    retired instructions, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter logic [4:0] HALT_OPCODE = 5'b11111,
  parameter logic [7:0] PC_RESET    = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step,
  input  logic        finish,
  input  logic [15:0] instr_in,
  input  logic        reg_write_in,
  input  logic        dm_write_in,
  input  logic        flags_write_in,
  input  logic        mem_access_in,
  input  logic        will_jump,
  output logic [7:0]  pc,
  output logic [15:0] ir,
  output logic        reg_we,
  output logic        dm_we,
  output logic        flags_we,
  output logic [2:0]  state,
  output logic        busy,
  output logic        halted,
  output logic [15:0] instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] count_q, count_d;
  logic        finish_pending_q, finish_pending_d;
  logic        step_mode_q, step_mode_d;
  logic        halt_now;

  // Any outstanding or current halt request, or the halt opcode itself,
  // stops the core once the current writeback commits.
  assign halt_now = finish_pending_q | finish | (ir_q[15:11] == HALT_OPCODE);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (run || step) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = mem_access_in ? S_MEM : S_WB;
      S_MEM:    state_d = S_WB;
      S_WB: begin
        if (halt_now) begin
          state_d = S_HALT;
        end else if (step_mode_q) begin
          state_d = S_IDLE;
        end else if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT:   state_d = S_HALT;
      // The unused encoding is treated as a fault and parks the core.
      default:  state_d = S_HALT;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: strobes and status decode from the current state only
  // -------------------------------------------------------------------------
  always_comb begin
    flags_we = 1'b0;
    dm_we    = 1'b0;
    reg_we   = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      S_FETCH, S_DECODE: busy = 1'b1;
      S_EXEC: begin
        busy     = 1'b1;
        flags_we = flags_write_in;
      end
      S_MEM: begin
        busy  = 1'b1;
        dm_we = dm_write_in;
      end
      S_WB: begin
        busy = 1'b1;
        // A store also decodes as a register write on some opcodes; the
        // register file must not see it.
        reg_we = reg_write_in & ~dm_write_in;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next-state: PC, IR, retire counter, mode flags
  // -------------------------------------------------------------------------
  always_comb begin
    pc_d             = pc_q;
    ir_d             = ir_q;
    count_d          = count_q;
    step_mode_d      = step_mode_q;
    finish_pending_d = finish_pending_q;

    if (state_q == S_IDLE && (run || step)) begin
      // run wins when both are asserted together.
      step_mode_d = step & ~run;
    end

    if (state_q == S_FETCH) begin
      ir_d = instr_in;
    end

    if (state_q == S_WB) begin
      pc_d = will_jump ? ir_q[8:1] : pc_q + 8'd1;
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
    end

    // Clearing on HALT entry takes priority over a simultaneous request.
    if (state_d == S_HALT) begin
      finish_pending_d = 1'b0;
    end else if (finish && state_q != S_HALT) begin
      finish_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q             <= PC_RESET;
      ir_q             <= 16'h0000;
      count_q          <= 16'h0000;
      step_mode_q      <= 1'b0;
      finish_pending_q <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      ir_q             <= ir_d;
      count_q          <= count_d;
      step_mode_q      <= step_mode_d;
      finish_pending_q <= finish_pending_d;
    end
  end

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Cycle-by-cycle scoreboard bench for cpu_sequencer. Each test pushes one
// entry per clock holding the expected outputs for that cycle plus the
// inputs to apply afterwards; the test then drains the queue, comparing on
// the falling edge and driving the next inputs.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run, step, finish;
  logic [15:0] instr_in;
  logic        reg_write_in, dm_write_in, flags_write_in, mem_access_in;
  logic        will_jump;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        reg_we, dm_we, flags_we;
  logic [2:0]  state;
  logic        busy, halted;
  logic [15:0] instr_count;

  logic [15:0] imem [256];
  logic        jump_en;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0]  st;
    logic [2:0]  we;   // {reg_we, dm_we, flags_we}
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [15:0] cnt;
    logic        d_run;
    logic        d_step;
    logic        d_fin;
    logic        d_rst;
  } exp_t;

  exp_t exp_q [$];

  always #5 clk = ~clk;

  // Asynchronous instruction memory and a jump unit that fires on opcode 00100.
  assign instr_in  = imem[pc];
  assign will_jump = jump_en & (ir[15:11] == 5'b00100);

  cpu_sequencer #(.HALT_OPCODE(5'b11111), .PC_RESET(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .finish(finish),
    .instr_in(instr_in), .reg_write_in(reg_write_in), .dm_write_in(dm_write_in),
    .flags_write_in(flags_write_in), .mem_access_in(mem_access_in),
    .will_jump(will_jump), .pc(pc), .ir(ir), .reg_we(reg_we), .dm_we(dm_we),
    .flags_we(flags_we), .state(state), .busy(busy), .halted(halted),
    .instr_count(instr_count)
  );

  task automatic push(input logic [2:0] st, input logic [2:0] we, input logic [7:0] p,
                      input logic [15:0] i, input logic [15:0] c,
                      input logic r, input logic s, input logic f, input logic rs);
    exp_t e;
    e.st = st; e.we = we; e.pc = p; e.ir = i; e.cnt = c;
    e.d_run = r; e.d_step = s; e.d_fin = f; e.d_rst = rs;
    exp_q.push_back(e);
  endtask

  // One instruction under run: FETCH, DECODE, EXEC, [MEM], WB.
  task automatic push_instr(input logic [7:0] p, input logic [15:0] prev_ir,
                            input logic [15:0] new_ir, input logic [15:0] c,
                            input logic rw, input logic dw, input logic fw,
                            input logic mem, input logic wb_run, input logic exec_fin);
    push(3'd1, 3'b000, p, prev_ir, c, 1'b1, 1'b0, 1'b0, 1'b1);
    push(3'd2, 3'b000, p, new_ir,  c, 1'b1, 1'b0, 1'b0, 1'b1);
    push(3'd3, {2'b00, fw}, p, new_ir, c, 1'b1, 1'b0, exec_fin, 1'b1);
    if (mem) push(3'd4, {1'b0, dw, 1'b0}, p, new_ir, c, 1'b1, 1'b0, 1'b0, 1'b1);
    push(3'd5, {rw & ~dw, 2'b00}, p, new_ir, c, wb_run, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic set_ctrl(input logic rw, input logic dw, input logic fw, input logic mem);
    reg_write_in = rw; dm_write_in = dw; flags_write_in = fw; mem_access_in = mem;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; step = 1'b0; finish = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (state !== 3'd0)          begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (pc !== 8'h00)            begin bad++; $display("FAIL reset_pc got=%h want=00", pc); end
    total++; if (ir !== 16'h0000)         begin bad++; $display("FAIL reset_ir got=%h want=0000", ir); end
    total++; if (instr_count !== 16'h0)   begin bad++; $display("FAIL reset_count got=%0d want=0", instr_count); end
    total++; if ({busy, halted} !== 2'b00) begin bad++; $display("FAIL reset_status got=%b want=00", {busy, halted}); end
    total++; if ({reg_we, dm_we, flags_we} !== 3'b000) begin bad++; $display("FAIL reset_strobes got=%b want=000", {reg_we, dm_we, flags_we}); end
    $display("reset checked: state=%0d pc=%h ir=%h cnt=%0d", state, pc, ir, instr_count);
    rst_n = 1'b1;
  endtask

  task automatic test_run_back_to_back();
    exp_t e;
    int   cyc = 0;
    set_ctrl(1'b1, 1'b0, 1'b1, 1'b0);
    push(3'd0, 3'b000, 8'h00, 16'h0000, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    push_instr(8'h00, 16'h0000, 16'h0800, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    push_instr(8'h01, 16'h0800, 16'h0800, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(3'd0, 3'b000, 8'h02, 16'h0800, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      cyc++; total++;
      if ({state, reg_we, dm_we, flags_we, busy, halted, pc, ir, instr_count} !==
          {e.st, e.we, (e.st >= 3'd1 && e.st <= 3'd5), (e.st == 3'd6), e.pc, e.ir, e.cnt}) begin
        bad++;
        $display("FAIL run_b2b cyc%0d: st=%0d we=%b bh=%b%b pc=%h ir=%h cnt=%0d want st=%0d we=%b pc=%h ir=%h cnt=%0d",
                 cyc, state, {reg_we, dm_we, flags_we}, busy, halted, pc, ir, instr_count, e.st, e.we, e.pc, e.ir, e.cnt);
      end else $display("run_b2b cyc%0d ok st=%0d pc=%h cnt=%0d", cyc, state, pc, instr_count);
      run = e.d_run; step = e.d_step; finish = e.d_fin; rst_n = e.d_rst;
    end
  endtask

  task automatic test_store();
    exp_t e;
    int   cyc = 0;
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b1);
    push(3'd0, 3'b000, 8'h02, 16'h0800, 16'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    push_instr(8'h02, 16'h0800, 16'h5000, 16'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    push(3'd0, 3'b000, 8'h03, 16'h5000, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      cyc++; total++;
      if ({state, reg_we, dm_we, flags_we, busy, halted, pc, ir, instr_count} !==
          {e.st, e.we, (e.st >= 3'd1 && e.st <= 3'd5), (e.st == 3'd6), e.pc, e.ir, e.cnt}) begin
        bad++;
        $display("FAIL store cyc%0d: st=%0d we=%b bh=%b%b pc=%h ir=%h cnt=%0d want st=%0d we=%b pc=%h ir=%h cnt=%0d",
                 cyc, state, {reg_we, dm_we, flags_we}, busy, halted, pc, ir, instr_count, e.st, e.we, e.pc, e.ir, e.cnt);
      end else $display("store cyc%0d ok st=%0d we=%b pc=%h", cyc, state, {reg_we, dm_we, flags_we}, pc);
      run = e.d_run; step = e.d_step; finish = e.d_fin; rst_n = e.d_rst;
    end
  endtask

  task automatic test_jump_wrap();
    exp_t e;
    int   cyc = 0;
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    push(3'd0, 3'b000, 8'h03, 16'h5000, 16'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    push_instr(8'h03, 16'h5000, 16'h2020, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_instr(8'h10, 16'h2020, 16'h2080, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_instr(8'h40, 16'h2080, 16'h21FE, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_instr(8'hFF, 16'h21FE, 16'h0800, 16'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd0, 3'b000, 8'h00, 16'h0800, 16'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      cyc++; total++;
      if ({state, reg_we, dm_we, flags_we, busy, halted, pc, ir, instr_count} !==
          {e.st, e.we, (e.st >= 3'd1 && e.st <= 3'd5), (e.st == 3'd6), e.pc, e.ir, e.cnt}) begin
        bad++;
        $display("FAIL jump_wrap cyc%0d: st=%0d we=%b bh=%b%b pc=%h ir=%h cnt=%0d want st=%0d we=%b pc=%h ir=%h cnt=%0d",
                 cyc, state, {reg_we, dm_we, flags_we}, busy, halted, pc, ir, instr_count, e.st, e.we, e.pc, e.ir, e.cnt);
      end else $display("jump_wrap cyc%0d ok st=%0d pc=%h ir=%h", cyc, state, pc, ir);
      run = e.d_run; step = e.d_step; finish = e.d_fin; rst_n = e.d_rst;
    end
  endtask

  task automatic test_step();
    exp_t e;
    int   cyc = 0;
    set_ctrl(1'b1, 1'b0, 1'b1, 1'b0);
    push(3'd0, 3'b000, 8'h00, 16'h0800, 16'd7, 1'b0, 1'b1, 1'b0, 1'b1);
    push(3'd1, 3'b000, 8'h00, 16'h0800, 16'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    push(3'd2, 3'b000, 8'h00, 16'h0800, 16'd7, 1'b0, 1'b1, 1'b0, 1'b1);  // ignored pulse
    push(3'd3, 3'b001, 8'h00, 16'h0800, 16'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    push(3'd5, 3'b100, 8'h00, 16'h0800, 16'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    push(3'd0, 3'b000, 8'h01, 16'h0800, 16'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    push(3'd0, 3'b000, 8'h01, 16'h0800, 16'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      cyc++; total++;
      if ({state, reg_we, dm_we, flags_we, busy, halted, pc, ir, instr_count} !==
          {e.st, e.we, (e.st >= 3'd1 && e.st <= 3'd5), (e.st == 3'd6), e.pc, e.ir, e.cnt}) begin
        bad++;
        $display("FAIL step cyc%0d: st=%0d we=%b bh=%b%b pc=%h ir=%h cnt=%0d want st=%0d we=%b pc=%h ir=%h cnt=%0d",
                 cyc, state, {reg_we, dm_we, flags_we}, busy, halted, pc, ir, instr_count, e.st, e.we, e.pc, e.ir, e.cnt);
      end else $display("step cyc%0d ok st=%0d pc=%h cnt=%0d", cyc, state, pc, instr_count);
      run = e.d_run; step = e.d_step; finish = e.d_fin; rst_n = e.d_rst;
    end
  endtask

  task automatic test_finish();
    exp_t e;
    int   cyc = 0;
    set_ctrl(1'b1, 1'b0, 1'b1, 1'b0);
    push(3'd0, 3'b000, 8'h01, 16'h0800, 16'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    push_instr(8'h01, 16'h0800, 16'h0800, 16'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    push(3'd6, 3'b000, 8'h02, 16'h0800, 16'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    push(3'd6, 3'b000, 8'h02, 16'h0800, 16'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    push(3'd6, 3'b000, 8'h02, 16'h0800, 16'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    push(3'd0, 3'b000, 8'h00, 16'h0000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      cyc++; total++;
      if ({state, reg_we, dm_we, flags_we, busy, halted, pc, ir, instr_count} !==
          {e.st, e.we, (e.st >= 3'd1 && e.st <= 3'd5), (e.st == 3'd6), e.pc, e.ir, e.cnt}) begin
        bad++;
        $display("FAIL finish cyc%0d: st=%0d we=%b bh=%b%b pc=%h ir=%h cnt=%0d want st=%0d we=%b pc=%h ir=%h cnt=%0d",
                 cyc, state, {reg_we, dm_we, flags_we}, busy, halted, pc, ir, instr_count, e.st, e.we, e.pc, e.ir, e.cnt);
      end else $display("finish cyc%0d ok st=%0d halted=%b pc=%h", cyc, state, halted, pc);
      run = e.d_run; step = e.d_step; finish = e.d_fin; rst_n = e.d_rst;
    end
  endtask

  task automatic test_halt_opcode();
    exp_t e;
    int   cyc = 0;
    imem[0] = 16'hF800;
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd0, 3'b000, 8'h00, 16'h0000, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    push_instr(8'h00, 16'h0000, 16'hF800, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(3'd6, 3'b000, 8'h01, 16'hF800, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(3'd6, 3'b000, 8'h01, 16'hF800, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(3'd0, 3'b000, 8'h00, 16'h0000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      cyc++; total++;
      if ({state, reg_we, dm_we, flags_we, busy, halted, pc, ir, instr_count} !==
          {e.st, e.we, (e.st >= 3'd1 && e.st <= 3'd5), (e.st == 3'd6), e.pc, e.ir, e.cnt}) begin
        bad++;
        $display("FAIL halt_op cyc%0d: st=%0d we=%b bh=%b%b pc=%h ir=%h cnt=%0d want st=%0d we=%b pc=%h ir=%h cnt=%0d",
                 cyc, state, {reg_we, dm_we, flags_we}, busy, halted, pc, ir, instr_count, e.st, e.we, e.pc, e.ir, e.cnt);
      end else $display("halt_op cyc%0d ok st=%0d pc=%h ir=%h", cyc, state, pc, ir);
      run = e.d_run; step = e.d_step; finish = e.d_fin; rst_n = e.d_rst;
    end
  endtask

  task automatic test_reset_mid_store();
    exp_t e;
    int   cyc = 0;
    imem[0] = 16'h5000;
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b1);
    push(3'd0, 3'b000, 8'h00, 16'h0000, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(3'd1, 3'b000, 8'h00, 16'h0000, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(3'd2, 3'b000, 8'h00, 16'h5000, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(3'd3, 3'b000, 8'h00, 16'h5000, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(3'd4, 3'b010, 8'h00, 16'h5000, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(3'd0, 3'b000, 8'h00, 16'h0000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(3'd0, 3'b000, 8'h00, 16'h0000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      cyc++; total++;
      if ({state, reg_we, dm_we, flags_we, busy, halted, pc, ir, instr_count} !==
          {e.st, e.we, (e.st >= 3'd1 && e.st <= 3'd5), (e.st == 3'd6), e.pc, e.ir, e.cnt}) begin
        bad++;
        $display("FAIL rst_mem cyc%0d: st=%0d we=%b bh=%b%b pc=%h ir=%h cnt=%0d want st=%0d we=%b pc=%h ir=%h cnt=%0d",
                 cyc, state, {reg_we, dm_we, flags_we}, busy, halted, pc, ir, instr_count, e.st, e.we, e.pc, e.ir, e.cnt);
      end else $display("rst_mem cyc%0d ok st=%0d dm_we=%b pc=%h", cyc, state, dm_we, pc);
      run = e.d_run; step = e.d_step; finish = e.d_fin; rst_n = e.d_rst;
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; finish = 1'b0;
    jump_en = 1'b1;
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) imem[i] = 16'h0800;
    imem[2]    = 16'h5000;  // store
    imem[3]    = 16'h2020;  // jump to 0x10
    imem[8'h10] = 16'h2080; // jump to 0x40
    imem[8'h40] = 16'h21FE; // jump to 0xFF

    test_reset();
    test_run_back_to_back();
    test_store();
    test_jump_wrap();
    test_step();
    test_finish();
    test_halt_opcode();
    test_reset_mid_store();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
